bsg_clk_gen_pearl_seq_ctrl: RTL
===============================

// Module: bsg_clk_gen_pearl_seq_ctrl
// PURPOSE
//  On-chip bring-up sequencer for num_clk_p v3 clock generators; removes per-field manual tag writes.
//  Accepts one valid/ready command per channel: park output, reset osc, program osc/ds, trigger, settle, select.
//  Drives the osc/ds/reset/select controls of each generator; one-cycle response pulse when a sequence ends.
//  Sits between the chip control/tag-client layer and the bank of bsg_clk_gen instances.
// PARAMETERS
//  num_clk_p          4   number of clock-generator channels (>=1)
//  osc_width_p        6   oscillator setting width per channel
//  ds_width_p         8   downsampler value width per channel
//  reset_hold_cycles_p 16 cycles osc_reset_o is held high in RESET (>=1)
//  settle_cycles_p    64  cycles spent in SETTLE before select is applied (>=1)
// PORTS
//  clk_i             in   1                 control clock; sole clock of the block
//  reset_n_i         in   1                 synchronous, active-low reset
//  output_disable_i  in   1                 level; forces every sel_o lane to 2'b11 (off)
//  cmd_v_i           in   1                 command valid
//  cmd_ready_o       out  1                 command ready (high only in IDLE)
//  cmd_id_i          in   lg(num_clk_p)     target channel, lg = `BSG_SAFE_CLOG2
//  cmd_osc_i         in   osc_width_p       oscillator setting
//  cmd_ds_i          in   ds_width_p        downsample value
//  cmd_sel_i         in   2                 final clock select
//  resp_v_o          out  1                 one-cycle completion pulse; no back-pressure
//  resp_id_o         out  lg(num_clk_p)     channel of completed command
//  resp_err_o        out  1                 1 = cmd_id_i >= num_clk_p, no outputs touched
//  busy_o            out  1                 state != IDLE
//  osc_reset_o       out  num_clk_p         per-channel osc reset
//  osc_trigger_o     out  num_clk_p         per-channel one-cycle osc load trigger
//  osc_o             out  num_clk_p*osc_width_p  packed osc settings, lane i at [i*osc_width_p+:osc_width_p]
//  ds_o              out  num_clk_p*ds_width_p   packed ds values
//  sel_o             out  num_clk_p*2            packed selects
// BEHAVIOUR
//  Reset (reset_n_i low at an edge): state IDLE; osc_reset_o all 1; osc_trigger_o 0; osc_o 0; ds_o 0;
//   sel register all 2'b11; resp_v_o 0, resp_id_o 0, resp_err_o 0; busy_o 0. cmd_ready_o = 0 while reset_n_i low.
//  Accept: cmd_v_i & cmd_ready_o at an edge; id/osc/ds/sel latched into holding registers.
//  States & per-edge actions (accept edge = cycle 0):
//   PARK     cycle 1: sel_r[id] = 2'b11.
//   RESET    cycles 2..H+1 (H = reset_hold_cycles_p): osc_reset_o[id] = 1, down-counter H-1..0.
//   PROGRAM  cycle H+2: osc_reset_o[id] = 0, osc lane = cmd osc, ds lane = cmd ds, osc_trigger_o[id] = 1.
//   SETTLE   cycles H+3..H+S+2 (S = settle_cycles_p): osc_trigger_o = 0, counter S-1..0.
//   SELECT   cycle H+S+3: sel_r[id] = cmd sel.
//   DONE     cycle H+S+4: resp_v_o = 1, resp_id_o = id, resp_err_o = 0; next edge -> IDLE.
//   IDLE     cmd_ready_o = 1 from cycle H+S+5.
//  Invalid id: IDLE -> DONE directly (resp_v_o at cycle 1, resp_err_o = 1); no channel output changes.
//  sel_o lane i = output_disable_i ? 2'b11 : sel_r[i], combinational, zero latency; FSM progress unaffected.
//  Other channels' outputs hold their values during any sequence; only lane id changes.
//  resp_id_o/resp_err_o hold last values when resp_v_o is 0.
//  Counters sized `BSG_SAFE_CLOG2 of max(H,S)+1; no wrap, terminal count 0 advances state.
//  Reset mid-sequence: abort, all outputs to reset values (all channels back in osc reset), no resp pulse.
//  cmd_v_i while busy: ignored (ready low); cmd fields may change freely when not accepted.
// TESTING
//  Reset, then idle 5 cycles -> osc_reset_o=4'b1111, sel_o=8'hFF, cmd_ready_o=1, resp_v_o never pulses.
//  H=16,S=64: cmd id=2 osc=6'h15 ds=8'h07 sel=2'b00 at cycle 0 -> osc_reset_o[2] high cycles 2..17,
//   trigger[2] only at 18, osc lane2=6'h15 & ds lane2=8'h07 from 18, sel lane2=00 from 83, resp_v/id=2 at 84, ready at 85.
//  output_disable_i=1 during/after sequence of test 2 -> sel_o=8'hFF immediately; drop -> lane2 returns 00, resp still at 84.
//  num_clk_p=3, cmd id=3 -> resp_v_o at cycle 1 with resp_err_o=1; all channel outputs unchanged.
//  reset_n_i low at cycle 40 of a sequence on id=1 -> next cycle all reset values, no resp_v_o; new cmd accepted after release.
//  Back-to-back cmds id=0 then id=1 with cmd_v_i held -> second accepted at cycle H+S+5, channel 0 settings retained.

Source files
------------

// File: rtl/bsg_clk_gen_pearl_seq_ctrl.sv
// Bring-up sequencer for a bank of clock generators: one command walks a channel through
// park, osc reset, program/trigger, settle and select, then pulses a one-cycle response.
module bsg_clk_gen_pearl_seq_ctrl #(
  parameter int unsigned num_clk_p           = 4,
  parameter int unsigned osc_width_p         = 6,
  parameter int unsigned ds_width_p          = 8,
  parameter int unsigned reset_hold_cycles_p = 16,
  parameter int unsigned settle_cycles_p     = 64,
  localparam int unsigned IdW = (num_clk_p > 1) ? $clog2(num_clk_p) : 1
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               output_disable_i,
  input  logic                               cmd_v_i,
  output logic                               cmd_ready_o,
  input  logic [IdW-1:0]                     cmd_id_i,
  input  logic [osc_width_p-1:0]             cmd_osc_i,
  input  logic [ds_width_p-1:0]              cmd_ds_i,
  input  logic [1:0]                         cmd_sel_i,
  output logic                               resp_v_o,
  output logic [IdW-1:0]                     resp_id_o,
  output logic                               resp_err_o,
  output logic                               busy_o,
  output logic [num_clk_p-1:0]               osc_reset_o,
  output logic [num_clk_p-1:0]               osc_trigger_o,
  output logic [num_clk_p*osc_width_p-1:0]   osc_o,
  output logic [num_clk_p*ds_width_p-1:0]    ds_o,
  output logic [num_clk_p*2-1:0]             sel_o
);

  localparam int unsigned CntMax = (reset_hold_cycles_p > settle_cycles_p) ?
                                   reset_hold_cycles_p : settle_cycles_p;
  localparam int unsigned CntW   = (CntMax > 0) ? $clog2(CntMax + 1) : 1;
  localparam logic [CntW-1:0] HoldLoad   = CntW'(reset_hold_cycles_p - 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(settle_cycles_p - 1);

  // Each state's register updates land on the edge that leaves it; StResp is the pulse cycle.
  typedef enum logic [2:0] {
    StIdle, StPark, StReset, StProgram, StSettle, StSelect, StDone, StResp
  } state_e;

  state_e                           r_state, w_state_next;
  logic                             w_accept, w_id_ok;
  logic [CntW-1:0]                  r_cnt;
  logic [IdW-1:0]                   r_id;
  logic [osc_width_p-1:0]           r_cmd_osc;
  logic [ds_width_p-1:0]            r_cmd_ds;
  logic [1:0]                       r_cmd_sel;
  logic                             r_cmd_err;
  logic [num_clk_p-1:0]             r_osc_reset, r_trigger;
  logic [num_clk_p*osc_width_p-1:0] r_osc;
  logic [num_clk_p*ds_width_p-1:0]  r_ds;
  logic [num_clk_p*2-1:0]           r_sel;
  logic [IdW-1:0]                   r_resp_id;
  logic                             r_resp_err;

  // A power-of-two channel count leaves no unused id codes.
  if ((1 << IdW) == num_clk_p) begin : g_id_full
    assign w_id_ok = 1'b1;
  end else begin : g_id_part
    assign w_id_ok = (32'(cmd_id_i) < num_clk_p);
  end

  assign w_accept = cmd_v_i & cmd_ready_o;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (w_accept) w_state_next = w_id_ok ? StPark : StDone;
      StPark:    w_state_next = StReset;
      StReset:   if (r_cnt == '0) w_state_next = StProgram;
      StProgram: w_state_next = StSettle;
      StSettle:  if (r_cnt == '0) w_state_next = StSelect;
      StSelect:  w_state_next = StDone;
      StDone:    w_state_next = StResp;
      StResp:    w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready_o = reset_n_i && (r_state == StIdle);
    busy_o      = (r_state != StIdle);
    resp_v_o    = (r_state == StResp);
    sel_o       = output_disable_i ? '1 : r_sel;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_cnt       <= '0;
      r_id        <= '0;
      r_cmd_osc   <= '0;
      r_cmd_ds    <= '0;
      r_cmd_sel   <= '0;
      r_cmd_err   <= 1'b0;
      r_osc_reset <= '1;
      r_trigger   <= '0;
      r_osc       <= '0;
      r_ds        <= '0;
      r_sel       <= '1;
      r_resp_id   <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_id      <= cmd_id_i;
        r_cmd_osc <= cmd_osc_i;
        r_cmd_ds  <= cmd_ds_i;
        r_cmd_sel <= cmd_sel_i;
        r_cmd_err <= !w_id_ok;
      end
      unique case (r_state)
        StPark: begin
          r_cnt <= HoldLoad;
          for (int i = 0; i < num_clk_p; i++) begin
            if (r_id == IdW'(i)) r_sel[2*i +: 2] <= 2'b11;
          end
        end
        StReset: begin
          for (int i = 0; i < num_clk_p; i++) begin
            if (r_id == IdW'(i)) r_osc_reset[i] <= 1'b1;
          end
          if (r_cnt != '0) r_cnt <= r_cnt - CntW'(1);
        end
        StProgram: begin
          r_cnt <= SettleLoad;
          for (int i = 0; i < num_clk_p; i++) begin
            if (r_id == IdW'(i)) begin
              r_osc_reset[i]                     <= 1'b0;
              r_trigger[i]                       <= 1'b1;
              r_osc[i*osc_width_p +: osc_width_p] <= r_cmd_osc;
              r_ds[i*ds_width_p +: ds_width_p]    <= r_cmd_ds;
            end
          end
        end
        StSettle: begin
          r_trigger <= '0;
          if (r_cnt != '0) r_cnt <= r_cnt - CntW'(1);
        end
        StSelect: begin
          for (int i = 0; i < num_clk_p; i++) begin
            if (r_id == IdW'(i)) r_sel[2*i +: 2] <= r_cmd_sel;
          end
        end
        StDone: begin
          r_resp_id  <= r_id;
          r_resp_err <= r_cmd_err;
        end
        default: ;
      endcase
    end
  end

  assign osc_reset_o   = r_osc_reset;
  assign osc_trigger_o = r_trigger;
  assign osc_o         = r_osc;
  assign ds_o          = r_ds;
  assign resp_id_o     = r_resp_id;
  assign resp_err_o    = r_resp_err;

endmodule
